// File: rtl/mult_acc.sv
// -----------------------------------------------------------------------------
// mult_acc
//   Pipelined signed multiply-accumulate with rounding and saturation.
//
//   A sample (a, b, acc_en, acc_clr) is taken into an input register when
//   valid_in and ce are high. The exact product is then carried through
//   LATENCY product stages, with the accumulate controls following in a
//   sideband pipeline. A final stage updates the accumulator, rounds the new
//   accumulator value to nearest (half toward +inf) after an arithmetic right
//   shift of SHIFT bits, and saturates it to OUT_WIDTH bits. A sample accepted
//   at edge N is presented after edge N+LATENCY+1.
//
// Parameters
//   WIDTH_A, WIDTH_B : signed operand widths
//   LATENCY          : product pipeline stages (1..6)
//   ACC_WIDTH        : accumulator width (>= WIDTH_A+WIDTH_B)
//   SHIFT            : output arithmetic right shift (0..ACC_WIDTH-1)
//   OUT_WIDTH        : output width (<= ACC_WIDTH)
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, wins over ce
//   ce        : clock enable; low freezes every register
//   valid_in  : a, b, acc_en, acc_clr carry a sample
//   a, b      : signed operands
//   acc_en    : add this product to the accumulator
//   acc_clr   : load the accumulator with this product (overrides acc_en)
//   valid_out : p and ovf carry a new result
//   p         : rounded, saturated result (holds while valid_out is low)
//   ovf       : saturation occurred on the current result
//   sat       : sticky saturation flag, cleared only by rst
// -----------------------------------------------------------------------------
module mult_acc #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int LATENCY   = 3,
  parameter int ACC_WIDTH = 48,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        valid_in,
  input  logic signed [WIDTH_A-1:0]   a,
  input  logic signed [WIDTH_B-1:0]   b,
  input  logic                        acc_en,
  input  logic                        acc_clr,
  output logic                        valid_out,
  output logic signed [OUT_WIDTH-1:0] p,
  output logic                        ovf,
  output logic                        sat
);

  localparam int WP = WIDTH_A + WIDTH_B;

  // Saturation limits expressed in the ACC_WIDTH+1 bit rounding domain.
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Input register and product pipeline (data only).
  logic signed [WIDTH_A-1:0] a_r;
  logic signed [WIDTH_B-1:0] b_r;
  logic signed [WP-1:0]      prod_sr [LATENCY];

  // Control sideband: bit 0 is the input register, bit k is product stage k.
  logic [LATENCY:0] vld_sr;
  logic [LATENCY:0] en_sr;
  logic [LATENCY:0] clr_sr;

  // Output-stage combinational results.
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic signed [ACC_WIDTH:0]   val_w;
  logic signed [ACC_WIDTH:0]   rnd;
  logic signed [OUT_WIDTH-1:0] p_nxt;
  logic                        ovf_nxt;

  // ---------------------------------------------------------------------------
  // Control sideband. Clearing it on rst is what discards every in-flight
  // sample, including one presented in the reset cycle itself.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, which is what makes the shift work.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      en_sr  <= '0;
      clr_sr <= '0;
    end else if (ce) begin
      vld_sr <= {vld_sr[LATENCY-1:0], valid_in};
      en_sr  <= {en_sr[LATENCY-1:0],  acc_en};
      clr_sr <= {clr_sr[LATENCY-1:0], acc_clr};
    end
  end

  // ---------------------------------------------------------------------------
  // Data pipeline.
  // ---------------------------------------------------------------------------
  // NOTE: the data registers carry no reset; a stale word is harmless because
  // the cleared valid sideband stops it from ever reaching the accumulator.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_r <= a;
      b_r <= b;
      // Both operands are widened before multiplying so the full product,
      // including min*min, is kept exactly.
      prod_sr[0] <= WP'(a_r) * WP'(b_r);
      for (int i = 1; i < LATENCY; i++) begin
        prod_sr[i] <= prod_sr[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate, round, saturate.
  // ---------------------------------------------------------------------------
  assign prod_ext = ACC_WIDTH'(prod_sr[LATENCY-1]);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    acc_nxt = prod_ext;
    if (!clr_sr[LATENCY] && en_sr[LATENCY]) begin
      acc_nxt = acc + prod_ext;
    end
  end

  // One extra bit so the rounding increment cannot overflow.
  assign val_w = (ACC_WIDTH+1)'(acc_nxt);

  generate
    if (SHIFT == 0) begin : g_no_round
      assign rnd = val_w;
    end else begin : g_round
      localparam logic signed [ACC_WIDTH:0] HALF =
        (ACC_WIDTH+1)'(1) << (SHIFT - 1);
      assign rnd = (val_w + HALF) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    p_nxt   = rnd[OUT_WIDTH-1:0];
    ovf_nxt = 1'b0;
    if (rnd > OUT_MAX) begin
      p_nxt   = OUT_MAX[OUT_WIDTH-1:0];
      ovf_nxt = 1'b1;
    end else if (rnd < OUT_MIN) begin
      p_nxt   = OUT_MIN[OUT_WIDTH-1:0];
      ovf_nxt = 1'b1;
    end
  end

  // Output stage. Bubbles advance valid_out only; acc, p, ovf and sat hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      p         <= '0;
      ovf       <= 1'b0;
      sat       <= 1'b0;
      valid_out <= 1'b0;
    end else if (ce) begin
      valid_out <= vld_sr[LATENCY];
      if (vld_sr[LATENCY]) begin
        acc <= acc_nxt;
        p   <= p_nxt;
        ovf <= ovf_nxt;
        sat <= sat | ovf_nxt;
      end
    end
  end

endmodule
